// File: rtl/counter_x3_if.sv
// Bus-side port bundle for the three-channel timer.
// The bus decoder is the master; the timer is the slave.
interface counter_x3_if;
  logic        ctrl_we;
  logic        counter_we;
  logic [31:0] peripheral_in;
  logic [31:0] counter_out;
  logic        counter0_out;
  logic        counter1_out;
  logic        counter2_out;
  logic [1:0]  counter_sel;

  modport master (
    output ctrl_we,
    output counter_we,
    output peripheral_in,
    input  counter_out,
    input  counter0_out,
    input  counter1_out,
    input  counter2_out,
    input  counter_sel
  );

  modport slave (
    input  ctrl_we,
    input  counter_we,
    input  peripheral_in,
    output counter_out,
    output counter0_out,
    output counter1_out,
    output counter2_out,
    output counter_sel
  );
endinterface

// File: rtl/counter_x3.sv
// Three-channel down-counter/timer: one-shot, rate and
// square-wave modes, selectable channel readback.
module counter_x3 #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  counter_x3_if.slave bus
);

  typedef enum logic [1:0] {
    ONESHOT  = 2'b00,
    PERIODIC = 2'b01,
    SQUARE   = 2'b10,
    STOPPED  = 2'b11
  } mode_t;

  logic [WIDTH-1:0] count  [3];
  logic [WIDTH-1:0] reload [3];
  mode_t            mode   [3];
  logic [2:0]       en;
  logic [2:0]       out;
  logic [1:0]       sel;

  logic [1:0]       tgt;
  logic             ctrl_ok;
  logic [1:0]       load_ch;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] one;

  assign tgt      = bus.peripheral_in[1:0];
  assign ctrl_ok  = bus.ctrl_we && (tgt != 2'd3);
  // a same-cycle load targets the newly selected channel
  assign load_ch  = ctrl_ok ? tgt : sel;
  assign load_val = WIDTH'(bus.peripheral_in);
  assign one      = WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel <= 2'd0;
      en  <= 3'b000;
      out <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        count[i]  <= '0;
        reload[i] <= '0;
        mode[i]   <= STOPPED;
      end
    end else begin
      if (ctrl_ok)
        sel <= tgt;
      for (int i = 0; i < 3; i++) begin
        if (ctrl_ok && tgt == 2'(i)) begin
          mode[i] <= mode_t'(bus.peripheral_in[3:2]);
          en[i]   <= bus.peripheral_in[4];
        end
        if (bus.counter_we && load_ch == 2'(i)) begin
          count[i]  <= load_val;
          reload[i] <= load_val;
          out[i]    <= 1'b0;
        end else if (ctrl_ok && tgt == 2'(i)) begin
          out[i] <= 1'b0;
        end else if (en[i]) begin
          unique case (mode[i])
            ONESHOT: begin
              if (count[i] != '0)
                count[i] <= count[i] - one;
              if (count[i] <= one)
                out[i] <= 1'b1;
            end
            PERIODIC: begin
              if (count[i] == one) begin
                count[i] <= reload[i];
                out[i]   <= 1'b1;
              end else begin
                out[i] <= 1'b0;
                if (count[i] != '0)
                  count[i] <= count[i] - one;
              end
            end
            SQUARE: begin
              if (count[i] == one) begin
                count[i] <= reload[i];
                out[i]   <= ~out[i];
              end else if (count[i] != '0) begin
                count[i] <= count[i] - one;
              end
            end
            STOPPED: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    bus.counter_out = 32'd0;
    case (sel)
      2'd0:    bus.counter_out = 32'(count[0]);
      2'd1:    bus.counter_out = 32'(count[1]);
      2'd2:    bus.counter_out = 32'(count[2]);
      default: bus.counter_out = 32'd0;
    endcase
  end

  assign bus.counter_sel  = sel;
  assign bus.counter0_out = out[0];
  assign bus.counter1_out = out[1];
  assign bus.counter2_out = out[2];

endmodule

// File: tb/tb_counter_x3.sv
// Self-checking bench for counter_x3: directed steps plus
// random bus traffic against a behavioural timer model.
module tb_counter_x3;

  logic clk;
  logic reset;
  int   nchecks;
  int   nerr;

  counter_x3_if bus ();

  counter_x3 #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_cnt  [3];
  logic [31:0] m_rel  [3];
  int          m_mode [3];
  bit          m_en   [3];
  bit          m_out  [3];
  int          m_sel;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sel = 0;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i]  = 0;
      m_rel[i]  = 0;
      m_mode[i] = 3;
      m_en[i]   = 0;
      m_out[i]  = 0;
    end
  endtask

  // one clock edge of the timer, written from the behaviour rules
  task automatic model_step(input bit cw, input bit lw,
                            input logic [31:0] d);
    bit busy [3];
    int t;
    t = int'(d[1:0]);
    for (int i = 0; i < 3; i++) busy[i] = 0;
    if (cw && t != 3) begin
      m_sel     = t;
      m_mode[t] = int'(d[3:2]);
      m_en[t]   = d[4];
      m_out[t]  = 0;
      busy[t]   = 1;
    end
    if (lw) begin
      m_cnt[m_sel] = d;
      m_rel[m_sel] = d;
      m_out[m_sel] = 0;
      busy[m_sel]  = 1;
    end
    for (int i = 0; i < 3; i++) begin
      if (!busy[i] && m_en[i] && m_mode[i] != 3) begin
        if (m_mode[i] == 0) begin
          if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
          if (m_cnt[i] == 0) m_out[i] = 1;
        end else if (m_cnt[i] == 1) begin
          m_cnt[i] = m_rel[i];
          m_out[i] = (m_mode[i] == 1) ? 1'b1 : !m_out[i];
        end else begin
          if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
          if (m_mode[i] == 1) m_out[i] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("counter_out", bus.counter_out, m_cnt[m_sel]);
    chk("counter_sel", 32'(bus.counter_sel), 32'(m_sel));
    chk("out0", 32'(bus.counter0_out), 32'(m_out[0]));
    chk("out1", 32'(bus.counter1_out), 32'(m_out[1]));
    chk("out2", 32'(bus.counter2_out), 32'(m_out[2]));
  endtask

  task automatic cyc(input bit cw, input bit lw,
                     input logic [31:0] d);
    bus.ctrl_we       = cw;
    bus.counter_we    = lw;
    bus.peripheral_in = d;
    @(posedge clk);
    model_step(cw, lw, d);
    #1;
    bus.ctrl_we    = 1'b0;
    bus.counter_we = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'd0);
  endtask

  initial begin
    nchecks = 0;
    nerr    = 0;
    reset   = 1'b1;
    bus.ctrl_we       = 1'b0;
    bus.counter_we    = 1'b0;
    bus.peripheral_in = 32'd0;
    model_reset();
    #12;
    chk("rst_cnt", bus.counter_out, 32'd0);
    chk("rst_sel", 32'(bus.counter_sel), 32'd0);
    reset = 1'b0;
    idle(2);

    // one-shot ch0, load 5
    cyc(1, 0, 32'h10);
    cyc(0, 1, 32'd5);
    chk("os_load", bus.counter_out, 32'd5);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 32'd0);
      chk("os_cnt", bus.counter_out, 32'(5 - i));
      chk("os_out", 32'(bus.counter0_out), 32'(i == 5));
    end
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 32'd0);
      chk("os_hold", 32'(bus.counter0_out), 32'd1);
    end

    // periodic ch1, load 4 then load 1
    cyc(1, 0, 32'h15);
    cyc(0, 1, 32'd4);
    for (int i = 1; i <= 20; i++) begin
      cyc(0, 0, 32'd0);
      chk("per_out", 32'(bus.counter1_out), 32'(i % 4 == 0));
      chk("per_cnt", bus.counter_out, 32'(4 - i % 4));
    end
    cyc(0, 1, 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 32'd0);
      chk("per1_out", 32'(bus.counter1_out), 32'd1);
    end

    // asynchronous reset mid-count
    cyc(0, 1, 32'd4);
    idle(2);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst_cnt", bus.counter_out, 32'd0);
    chk("arst_o0", 32'(bus.counter0_out), 32'd0);
    chk("arst_o1", 32'(bus.counter1_out), 32'd0);
    chk("arst_o2", 32'(bus.counter2_out), 32'd0);
    chk("arst_sel", 32'(bus.counter_sel), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(3);
    chk("post_rst", bus.counter_out, 32'd0);

    // square ch2, load 3, pause, resume
    cyc(1, 0, 32'h1A);
    cyc(0, 1, 32'd3);
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 0, 32'd0);
      chk("sq_out", 32'(bus.counter2_out), 32'((i / 3) % 2));
      chk("sq_cnt", bus.counter_out, 32'(3 - i % 3));
    end
    idle(1);
    cyc(1, 0, 32'h0A);
    idle(7);
    chk("sq_frz", bus.counter_out, 32'd2);
    cyc(1, 0, 32'h1A);
    idle(8);

    // select mux and ignored write
    cyc(1, 0, 32'h10);
    cyc(0, 1, 32'd100);
    cyc(1, 0, 32'h15);
    cyc(0, 1, 32'd200);
    idle(2);
    cyc(1, 0, 32'h10);
    chk("sel0", 32'(bus.counter_sel), 32'd0);
    cyc(1, 0, 32'h15);
    chk("sel1", 32'(bus.counter_sel), 32'd1);
    cyc(1, 0, 32'h1F);
    chk("bad_sel", 32'(bus.counter_sel), 32'd1);
    idle(2);

    // simultaneous strobes: select ch2 and load it
    cyc(1, 1, 32'h112);
    chk("sim_cnt", bus.counter_out, 32'h112);
    chk("sim_sel", 32'(bus.counter_sel), 32'd2);
    idle(2);

    // one-shot load 0
    cyc(1, 0, 32'h10);
    cyc(0, 1, 32'd0);
    chk("os0_a", 32'(bus.counter0_out), 32'd0);
    cyc(0, 0, 32'd0);
    chk("os0_b", 32'(bus.counter0_out), 32'd1);

    // periodic load 0 is inert
    cyc(1, 0, 32'h15);
    cyc(0, 1, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 32'd0);
      chk("p0_cnt", bus.counter_out, 32'd0);
      chk("p0_out", 32'(bus.counter1_out), 32'd0);
    end

    // full-scale load
    cyc(0, 1, 32'hFFFF_FFFF);
    chk("max_a", bus.counter_out, 32'hFFFF_FFFF);
    cyc(0, 0, 32'd0);
    chk("max_b", bus.counter_out, 32'hFFFF_FFFE);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [31:0] d;
      r = int'($urandom_range(0, 9));
      d = {27'd0, 1'($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3))};
      if (r == 0)
        cyc(1, 0, d);
      else if (r == 1)
        cyc(0, 1, 32'($urandom_range(0, 8)));
      else if (r == 2)
        cyc(1, 1, d | 32'($urandom_range(0, 6) << 5));
      else if (r == 3 && $urandom_range(0, 9) == 0)
        cyc(0, 1, $urandom);
      else
        cyc(0, 0, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerr);
    $finish;
  end

endmodule
